// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame geometry and the
// odd-parity helper used by both the receiver and the host transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    // Parity bit that makes the 9-bit {parity, byte} group have odd weight.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pad conditioning: 2-flop synchronisers on clock and data, a
// FILTER_LEN-deep deglitch filter on the clock, and a falling-edge strobe.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2d_s,
    output logic fall_edge
);

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] filt_reg;
    logic [FILTER_LEN-1:0] filt_next;
    logic                  f_ps2c_reg;
    logic                  f_ps2c_next;

    // Idle bus level is high, so everything resets to ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync     <= '1;
            d_sync     <= '1;
            filt_reg   <= '1;
            f_ps2c_reg <= 1'b1;
        end else begin
            c_sync     <= {c_sync[0], ps2c};
            d_sync     <= {d_sync[0], ps2d};
            filt_reg   <= filt_next;
            f_ps2c_reg <= f_ps2c_next;
        end
    end

    // Decide on the shifted-in window so the edge is seen FILTER_LEN cycles
    // after the synchronised level first changes.
    always_comb begin
        filt_next   = {c_sync[1], filt_reg[FILTER_LEN-1:1]};
        f_ps2c_next = f_ps2c_reg;
        if (filt_next == '1)
            f_ps2c_next = 1'b1;
        else if (filt_next == '0)
            f_ps2c_next = 1'b0;
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;
    assign ps2d_s    = d_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises start, 8 data bits LSB-first,
// odd parity and stop, reporting the byte with parity/framing status pulses.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_idle
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic ps2d_s;
    logic fall_edge;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .ps2d_s    (ps2d_s),
        .fall_edge (fall_edge)
    );

    rx_state_t                state, state_next;
    logic [3:0]               n, n_next;
    logic [PS2_DATA_BITS:0]   b, b_next;
    logic [TW-1:0]            tcnt, tcnt_next;
    logic [PS2_DATA_BITS-1:0] dout_reg, dout_next;
    logic                     done_reg, done_next;
    logic                     perr_reg, perr_next;
    logic                     ferr_reg, ferr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            n        <= '0;
            b        <= '0;
            tcnt     <= '0;
            dout_reg <= '0;
            done_reg <= 1'b0;
            perr_reg <= 1'b0;
            ferr_reg <= 1'b0;
        end else begin
            state    <= state_next;
            n        <= n_next;
            b        <= b_next;
            tcnt     <= tcnt_next;
            dout_reg <= dout_next;
            done_reg <= done_next;
            perr_reg <= perr_next;
            ferr_reg <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        n_next     = n;
        b_next     = b;
        tcnt_next  = tcnt;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        perr_next  = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge && rx_en && !ps2d_s) begin
                    n_next     = 4'd8;
                    tcnt_next  = '0;
                    state_next = DATA;
                end
            end
            DATA, STOP: begin
                // Aborts take priority over an edge landing on the same cycle.
                if (!rx_en) begin
                    state_next = IDLE;
                end else if (tcnt == TMAX) begin
                    state_next = IDLE;
                    ferr_next  = 1'b1;
                end else if (fall_edge) begin
                    tcnt_next = '0;
                    if (state == DATA) begin
                        b_next = {ps2d_s, b[PS2_DATA_BITS:1]};
                        if (n == 4'd0)
                            state_next = STOP;
                        else
                            n_next = n - 4'd1;
                    end else begin
                        state_next = IDLE;
                        dout_next  = b[PS2_DATA_BITS-1:0];
                        perr_next  = b[PS2_DATA_BITS] != odd_parity(b[PS2_DATA_BITS-1:0]);
                        ferr_next  = ~ps2d_s;
                        done_next  = 1'b1;
                    end
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout         = dout_reg;
    assign rx_done_tick = done_reg;
    assign parity_err   = perr_reg;
    assign frame_err    = ferr_reg;
    assign rx_idle      = (state == IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed and randomised frames against a
// frame-level model, plus glitch, timeout, rx_en and mid-frame reset cases.
module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 20;
    localparam int LAT        = 2 + FILTER_LEN;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       rx_idle;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .rx_idle      (rx_idle)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_fall = 0;
    int pulse_cnt = 0;
    int busy_cnt = 0;
    int to_cnt = 0;
    int to_cyc = 0;
    logic [9:0] recq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completion as {dout, parity_err, frame_err}.
    always @(negedge clk) begin
        if (rx_done_tick) recq.push_back({dout, parity_err, frame_err});
        if (rx_done_tick || parity_err || frame_err) pulse_cnt <= pulse_cnt + 1;
        if (frame_err && !rx_done_tick) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
        if (!rx_idle) busy_cnt <= busy_cnt + 1;
    end

    // Model: what a completed frame must report.
    function automatic logic [9:0] rec_model(input logic [7:0] d, input logic par, input logic stp);
        logic perr;
        perr = ((^d) ^ par) == 1'b0;
        return {d, perr, ~stp};
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Send bits [first, first+nbits) of a frame, LSB first.
    task automatic send_bits(input logic [10:0] fr, input int first, input int nbits);
        for (int i = first; i < first + nbits; i++) begin
            ps2d = fr[i];
            wait_cyc(HALF);
            ps2c = 1'b0;
            last_fall = cyc;
            wait_cyc(HALF);
            ps2c = 1'b1;
        end
        wait_cyc(HALF);
        ps2d = 1'b1;
    endtask

    task automatic test_reset;
        wait_cyc(4);
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({dout, rx_done_tick, parity_err, frame_err, rx_idle} !== {8'h00, 4'b0001})
            $display("FAIL reset_state got %h/%b%b%b%b exp 00/0001", dout, rx_done_tick, parity_err, frame_err, rx_idle);
        else n_pass++;
        wait_cyc(1);
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic par, input logic stp);
        logic [9:0] exp, got;
        recq.delete();
        exp = rec_model(d, par, stp);
        send_bits(mk_frame(d, par, stp), 0, 11);
        wait_cyc(10);
        n_total++;
        if (recq.size() != 1) begin
            $display("FAIL %s_count got %0d exp 1", name, recq.size());
        end else begin
            n_pass++;
            got = recq.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL %s_rec got %h exp %h", name, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_glitch;
        int p0, b0;
        p0 = pulse_cnt; b0 = busy_cnt;
        ps2d = 1'b0;
        ps2c = 1'b0;
        wait_cyc(4);
        ps2c = 1'b1;
        wait_cyc(30);
        ps2d = 1'b1;
        n_total++;
        if (busy_cnt != b0 || pulse_cnt != p0 || rx_idle !== 1'b1)
            $display("FAIL glitch busy=%0d pulses=%0d exp 0/0", busy_cnt - b0, pulse_cnt - p0);
        else n_pass++;
        test_frame("glitch_aa", 8'hAA, 1'b1, 1'b1);
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic par, stp;
        for (int k = 0; k < 8; k++) begin
            d   = 8'($urandom);
            par = ~(^d) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 3) != 0);
            test_frame("random", d, par, stp);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d0, d1;
        logic [9:0] got;
        recq.delete();
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        send_bits(mk_frame(d0, ~(^d0), 1'b1), 0, 11);
        send_bits(mk_frame(d1, ~(^d1), 1'b1), 0, 11);
        wait_cyc(10);
        n_total++;
        if (recq.size() != 2) $display("FAIL b2b_count got %0d exp 2", recq.size());
        else n_pass++;
        if (recq.size() == 2) begin
            got = recq.pop_front();
            n_total++;
            if (got !== rec_model(d0, ~(^d0), 1'b1)) $display("FAIL b2b_first got %h exp %h", got, rec_model(d0, ~(^d0), 1'b1));
            else n_pass++;
            got = recq.pop_front();
            n_total++;
            if (got !== rec_model(d1, ~(^d1), 1'b1)) $display("FAIL b2b_second got %h exp %h", got, rec_model(d1, ~(^d1), 1'b1));
            else n_pass++;
        end
    endtask

    task automatic test_timeout;
        logic [7:0] prev;
        int t0, waited;
        prev = dout;
        t0 = to_cnt;
        recq.delete();
        ps2d = 1'b0;
        wait_cyc(HALF);
        ps2c = 1'b0;
        last_fall = cyc;
        wait_cyc(HALF);
        ps2c = 1'b1;
        send_bits(mk_frame(8'h3C, 1'b1, 1'b1), 1, 4);
        waited = 0;
        while (to_cnt == t0 && waited < TIMEOUT + 100) begin
            wait_cyc(1);
            waited++;
        end
        n_total++;
        if (to_cnt != t0 + 1) $display("FAIL timeout_pulse got %0d exp 1", to_cnt - t0);
        else n_pass++;
        n_total++;
        if ((to_cyc - last_fall) < LAT + TIMEOUT - 1 || (to_cyc - last_fall) > LAT + TIMEOUT + 1)
            $display("FAIL timeout_delay got %0d exp %0d", to_cyc - last_fall, LAT + TIMEOUT);
        else n_pass++;
        n_total++;
        if (rx_idle !== 1'b1 || dout !== prev || recq.size() != 0)
            $display("FAIL timeout_state idle=%b dout=%h done=%0d exp 1/%h/0", rx_idle, dout, recq.size(), prev);
        else n_pass++;
        test_frame("after_timeout", 8'h1C, 1'b0, 1'b1);
    endtask

    task automatic test_rx_en_abort;
        logic [7:0] prev;
        logic [10:0] fr;
        int p0;
        prev = dout;
        p0 = pulse_cnt;
        fr = mk_frame(8'h96, 1'b1, 1'b1);
        send_bits(fr, 0, 4);
        n_total++;
        if (rx_idle !== 1'b0) $display("FAIL rx_en_busy got %b exp 0", rx_idle);
        else n_pass++;
        rx_en = 1'b0;
        wait_cyc(2);
        n_total++;
        if (rx_idle !== 1'b1) $display("FAIL rx_en_idle got %b exp 1", rx_idle);
        else n_pass++;
        send_bits(fr, 4, 7);
        n_total++;
        if (pulse_cnt != p0 || dout !== prev || rx_idle !== 1'b1)
            $display("FAIL rx_en_quiet pulses=%0d dout=%h exp 0/%h", pulse_cnt - p0, dout, prev);
        else n_pass++;
        rx_en = 1'b1;
    endtask

    task automatic test_mid_reset;
        int p0;
        p0 = pulse_cnt;
        send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 0, 5);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({dout, rx_done_tick, parity_err, frame_err, rx_idle} !== {8'h00, 4'b0001} || pulse_cnt != p0)
            $display("FAIL mid_reset got %h/%b%b%b%b exp 00/0001", dout, rx_done_tick, parity_err, frame_err, rx_idle);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_cyc(5);
        test_frame("after_reset", 8'hE7, ~(^8'hE7), 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame("clean_1c", 8'h1C, 1'b0, 1'b1);
        test_frame("parity_f0", 8'hF0, 1'b0, 1'b1);
        test_frame("stop_55", 8'h55, 1'b1, 1'b0);
        test_glitch();
        test_random();
        test_back_to_back();
        test_timeout();
        test_rx_en_abort();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
